jtag_tap_ctrl: RTL and testbench
================================

Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller, instruction register and test-data-register (TDR) shift chain for the BIST block.
- Directly upstream of the BIST block: generates TLR, UPDATEDR, RUNBIST_SELECT, GETTEST_SELECT and the 10-bit BSR parallel word.
- Also consumes the BIST's 16-bit BIST_STATUS word so it can be shifted out on TDO.

Parameters:
- IR_WIDTH, 4, instruction register width.
- BSR_WIDTH, 10, GETTEST data register width; split as config[9:5] / check[4:0].
- STATUS_WIDTH, 16, width of the captured BIST_STATUS word.
- IDCODE_VAL, 32'h1BEEF0A1, device ID; bit 0 must be 1.
- OP_IDCODE, 4'h1, opcode selecting the 32-bit ID register.
- OP_GETTEST, 4'h8, opcode selecting the BSR load chain.
- OP_RUNBIST, 4'h9, opcode selecting the 1-bit bypass chain and asserting RUNBIST_SELECT.
- OP_STATUS, 4'hA, opcode selecting the BIST_STATUS capture chain.
- OP_BYPASS, 4'hF, 1-bit bypass; any undefined opcode also maps to bypass.

Ports:
- TCK  in  1  test clock, sole clock; rising edge except TDO.
- TRST  in  1  asynchronous active-low reset.
- TMS  in  1  test mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out, registered on falling TCK.
- TDO_EN  out  1  high while shifting IR or DR.
- TLR  out  1  high while FSM is in Test-Logic-Reset.
- UPDATEDR  out  1  high for exactly the one TCK cycle spent in Update-DR.
- CAPTUREDR  out  1  high for the one TCK cycle spent in Capture-DR.
- RUNBIST_SELECT  out  1  IR == OP_RUNBIST.
- GETTEST_SELECT  out  1  IR == OP_GETTEST.
- BSR  out  BSR_WIDTH  parallel update register of the GETTEST chain.
- BIST_STATUS  in  STATUS_WIDTH  status word from the BIST block.

Behaviour:
- FSM: standard 16 states (TLR, RTI, Sel-DR, Cap-DR, Sh-DR, Ex1-DR, Pa-DR, Ex2-DR, Upd-DR, and the matching IR states).
  - Transitions follow IEEE 1149.1 on the TMS value at each rising TCK.
  - TLR with TMS=0 goes to RTI; Sel-IR with TMS=1 goes to TLR.
  - Five consecutive TMS=1 edges reach TLR from any state.
- State-decoded outputs: TLR, UPDATEDR and CAPTUREDR are decoded from the state register, so they are glitch-free and never combinational from TMS.
- TRST low (async): state=TLR, IR=OP_IDCODE, IR/DR shift regs=0, BSR=0, TDO=0, TDO_EN=0.
  - Resulting outputs: TLR=1, UPDATEDR=0, CAPTUREDR=0, RUNBIST_SELECT=0, GETTEST_SELECT=0.
  - TRST mid-shift aborts the shift; no update occurs.
- Entering TLR synchronously sets IR=OP_IDCODE. BSR is held, not cleared.
- IR path:
  - Cap-IR loads the IR shift reg with 4'b0001.
  - Sh-IR shifts right: TDI into the MSB, the LSB feeds TDO.
  - Upd-IR copies the shift reg into IR. IR changes only there, or in TLR/reset.
- DR selection follows the current IR.
  - IDCODE: 32-bit chain, captures IDCODE_VAL.
  - GETTEST: BSR_WIDTH chain, captures the current BSR value.
  - STATUS: STATUS_WIDTH chain, captures BIST_STATUS in Cap-DR.
  - RUNBIST, BYPASS and undefined opcodes: 1-bit chain, captures 0.
- All DR chains shift right (LSB first out, TDI into the MSB) in Sh-DR only. Pause and Exit states hold the chain contents.
- BSR update timing:
  - BSR loads from the GETTEST shift reg on the rising edge whose next state is Upd-DR, and only when IR == OP_GETTEST.
  - This makes BSR valid during the whole Upd-DR cycle, so the downstream BIST samples GETTEST_SELECT & UPDATEDR & BSR on the edge leaving Upd-DR.
- UPDATEDR pulses for every DR update regardless of IR. Downstream qualifies it with GETTEST_SELECT.
- TDO timing:
  - On falling TCK: TDO <= LSB of the selected shift reg and TDO_EN <= 1 when the state is Sh-IR or Sh-DR.
  - Otherwise TDO <= 0 and TDO_EN <= 0.
  - First bit out after Cap-xR is the captured LSB.
- Back-to-back Upd-DR → Sel-DR → Cap-DR is legal. Each Upd-DR produces one UPDATEDR pulse, so consecutive GETTEST loads are not lost.
- Pause-DR: arbitrary dwell with no shift, then resume through Ex2-DR → Sh-DR with the chain intact.

Test Plan:
- Reset and recovery: TRST=0, then release with TMS=1 for 5 TCK → TLR=1, IR=4'h1, BSR=0, TDO_EN=0. A single TMS=0 edge → RTI, TLR=0.
- IDCODE read: from RTI, go to Sh-DR and shift 32 bits → TDO stream LSB-first equals 32'h1BEEF0A1. TDO_EN=1 exactly during the 32 shift cycles.
- IR scan: shift IR=4'h8 → captured IR bits read on TDO equal 1,0,0,0. After Upd-IR, GETTEST_SELECT=1 and RUNBIST_SELECT=0.
- GETTEST load: shift 10'h2A5 LSB-first, then Ex1-DR → Upd-DR → BSR=10'h2A5 during Upd-DR, UPDATEDR high for exactly 1 cycle. A second load of 10'h13C back-to-back → a second pulse with BSR=10'h13C.
- STATUS and bypass: IR=4'hA with BIST_STATUS=16'hC35F → 16 TDO bits LSB-first equal 16'hC35F. IR=4'h3 (undefined) → TDI appears on TDO delayed by 1 shift cycle, first bit 0.
- Abort: TRST asserted midway through a GETTEST Sh-DR → BSR stays 0, no UPDATEDR pulse, TLR=1 immediately (async).

Source files
------------

// File: rtl/jtag_tap_ctrl_if.sv
// JTAG TAP pins plus the BIST-facing side-band signals of the TAP controller.
// The master modport is the tester/driver side; the slave modport is the TAP.
interface jtag_tap_ctrl_if #(
    parameter int BSR_WIDTH    = 10,
    parameter int STATUS_WIDTH = 16
);
    logic                    TMS;
    logic                    TDI;
    logic                    TDO;
    logic                    TDO_EN;
    logic                    TLR;
    logic                    UPDATEDR;
    logic                    CAPTUREDR;
    logic                    RUNBIST_SELECT;
    logic                    GETTEST_SELECT;
    logic [BSR_WIDTH-1:0]    BSR;
    logic [STATUS_WIDTH-1:0] BIST_STATUS;

    modport master (
        output TMS, TDI, BIST_STATUS,
        input  TDO, TDO_EN, TLR, UPDATEDR, CAPTUREDR,
               RUNBIST_SELECT, GETTEST_SELECT, BSR
    );

    modport slave (
        input  TMS, TDI, BIST_STATUS,
        output TDO, TDO_EN, TLR, UPDATEDR, CAPTUREDR,
               RUNBIST_SELECT, GETTEST_SELECT, BSR
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller for the BIST block: 16-state FSM,
// instruction register, IDCODE/GETTEST/STATUS/bypass data chains and the
// BSR parallel update register. TDO is launched on the falling TCK edge.
module jtag_tap_ctrl #(
    parameter int                     IR_WIDTH     = 4,
    parameter int                     BSR_WIDTH    = 10,
    parameter int                     STATUS_WIDTH = 16,
    parameter logic [31:0]            IDCODE_VAL   = 32'h1BEEF0A1,
    parameter logic [IR_WIDTH-1:0]    OP_IDCODE    = 4'h1,
    parameter logic [IR_WIDTH-1:0]    OP_GETTEST   = 4'h8,
    parameter logic [IR_WIDTH-1:0]    OP_RUNBIST   = 4'h9,
    parameter logic [IR_WIDTH-1:0]    OP_STATUS    = 4'hA,
    parameter logic [IR_WIDTH-1:0]    OP_BYPASS    = 4'hF
) (
    input  logic                 TCK,
    input  logic                 TRST,
    jtag_tap_ctrl_if.slave       bus
);

    // Value presented by the IR chain in Capture-IR (LSB=1 as 1149.1 requires)
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        ST_TLR, ST_RTI,
        ST_SEL_DR, ST_CAP_DR, ST_SH_DR, ST_EX1_DR, ST_PA_DR, ST_EX2_DR, ST_UPD_DR,
        ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR, ST_PA_IR, ST_EX2_IR, ST_UPD_IR
    } tap_state_t;

    tap_state_t              state, next_state;
    logic [IR_WIDTH-1:0]     ir, ir_sr;
    logic [31:0]             id_sr;
    logic [BSR_WIDTH-1:0]    gt_sr, bsr;
    logic [STATUS_WIDTH-1:0] st_sr;
    logic                    byp_sr;
    logic                    tdo, tdo_en;
    logic                    tlr, updatedr, capturedr, cap_ir, sh_ir, upd_ir, sh_dr;
    logic                    sel_id, sel_gt, sel_st;
    logic                    dr_lsb;

    // State register; TRST forces Test-Logic-Reset immediately
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state <= ST_TLR;
        else       state <= next_state;
    end

    // Standard 1149.1 transition table on TMS
    always_comb begin
        next_state = state;
        unique case (state)
            ST_TLR:    next_state = bus.TMS ? ST_TLR    : ST_RTI;
            ST_RTI:    next_state = bus.TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_DR: next_state = bus.TMS ? ST_SEL_IR : ST_CAP_DR;
            ST_CAP_DR: next_state = bus.TMS ? ST_EX1_DR : ST_SH_DR;
            ST_SH_DR:  next_state = bus.TMS ? ST_EX1_DR : ST_SH_DR;
            ST_EX1_DR: next_state = bus.TMS ? ST_UPD_DR : ST_PA_DR;
            ST_PA_DR:  next_state = bus.TMS ? ST_EX2_DR : ST_PA_DR;
            ST_EX2_DR: next_state = bus.TMS ? ST_UPD_DR : ST_SH_DR;
            ST_UPD_DR: next_state = bus.TMS ? ST_SEL_DR : ST_RTI;
            ST_SEL_IR: next_state = bus.TMS ? ST_TLR    : ST_CAP_IR;
            ST_CAP_IR: next_state = bus.TMS ? ST_EX1_IR : ST_SH_IR;
            ST_SH_IR:  next_state = bus.TMS ? ST_EX1_IR : ST_SH_IR;
            ST_EX1_IR: next_state = bus.TMS ? ST_UPD_IR : ST_PA_IR;
            ST_PA_IR:  next_state = bus.TMS ? ST_EX2_IR : ST_PA_IR;
            ST_EX2_IR: next_state = bus.TMS ? ST_UPD_IR : ST_SH_IR;
            ST_UPD_IR: next_state = bus.TMS ? ST_SEL_DR : ST_RTI;
            default:   next_state = ST_TLR;
        endcase
    end

    // State-decoded strobes, taken from the register only so they never glitch on TMS
    always_comb begin
        tlr       = (state == ST_TLR);
        updatedr  = (state == ST_UPD_DR);
        capturedr = (state == ST_CAP_DR);
        sh_dr     = (state == ST_SH_DR);
        cap_ir    = (state == ST_CAP_IR);
        sh_ir     = (state == ST_SH_IR);
        upd_ir    = (state == ST_UPD_IR);
    end

    // Data-register select from the active instruction; unknown opcodes fall to bypass
    always_comb begin
        sel_id = (ir == OP_IDCODE);
        sel_gt = (ir == OP_GETTEST);
        sel_st = (ir == OP_STATUS);
        dr_lsb = byp_sr;
        if (sel_id)      dr_lsb = id_sr[0];
        else if (sel_gt) dr_lsb = gt_sr[0];
        else if (sel_st) dr_lsb = st_sr[0];
    end

    // Instruction register and its shift chain; IR only changes in Update-IR or TLR
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir    <= OP_IDCODE;
            ir_sr <= '0;
        end else begin
            if (cap_ir)     ir_sr <= IR_CAPTURE;
            else if (sh_ir) ir_sr <= {bus.TDI, ir_sr[IR_WIDTH-1:1]};
            if (next_state == ST_TLR) ir <= OP_IDCODE;
            else if (upd_ir)          ir <= ir_sr;
        end
    end

    // Data chains: only the selected chain captures or shifts; Pause/Exit hold contents
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            id_sr  <= '0;
            gt_sr  <= '0;
            st_sr  <= '0;
            byp_sr <= 1'b0;
        end else if (capturedr) begin
            if (sel_id)      id_sr  <= IDCODE_VAL;
            else if (sel_gt) gt_sr  <= bsr;
            else if (sel_st) st_sr  <= bus.BIST_STATUS;
            else             byp_sr <= 1'b0;
        end else if (sh_dr) begin
            if (sel_id)      id_sr  <= {bus.TDI, id_sr[31:1]};
            else if (sel_gt) gt_sr  <= {bus.TDI, gt_sr[BSR_WIDTH-1:1]};
            else if (sel_st) st_sr  <= {bus.TDI, st_sr[STATUS_WIDTH-1:1]};
            else             byp_sr <= bus.TDI;
        end
    end

    // BSR loads on the edge entering Update-DR so it is already valid for the whole pulse
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST)                                           bsr <= '0;
        else if (next_state == ST_UPD_DR && ir == OP_GETTEST) bsr <= gt_sr;
    end

    // TDO/TDO_EN launched on falling TCK so the tester samples a stable bit on the rising edge
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else if (sh_ir) begin
            tdo    <= ir_sr[0];
            tdo_en <= 1'b1;
        end else if (sh_dr) begin
            tdo    <= dr_lsb;
            tdo_en <= 1'b1;
        end else begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end
    end

    assign bus.TDO            = tdo;
    assign bus.TDO_EN         = tdo_en;
    assign bus.TLR            = tlr;
    assign bus.UPDATEDR       = updatedr;
    assign bus.CAPTUREDR      = capturedr;
    assign bus.RUNBIST_SELECT = (ir == OP_RUNBIST);
    assign bus.GETTEST_SELECT = sel_gt;
    assign bus.BSR            = bsr;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed testbench for jtag_tap_ctrl: reset, IDCODE, pause, IR scan,
// GETTEST loads, STATUS, bypass, TLR entry and TRST abort.
module tb_jtag_tap_ctrl;

    logic TCK = 1'b0;
    logic TRST;
    int   n_checks = 0;
    int   n_fail   = 0;

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl dut (
        .TCK  (TCK),
        .TRST (TRST),
        .bus  (bus)
    );

    always #5 TCK = ~TCK;

    // One TCK cycle: drive TMS/TDI, take the rising edge, settle after the falling edge
    task automatic step(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    // Starting in a Shift state, shift n bits; the last bit leaves via Exit1
    task automatic shift_bits(input int n, input logic [31:0] din,
                              output logic [31:0] dout, output int en_cnt);
        dout   = '0;
        en_cnt = 0;
        for (int i = 0; i < n; i++) begin
            dout[i] = bus.TDO;
            if (bus.TDO_EN === 1'b1) en_cnt++;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic goto_shdr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic finish_dr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // RTI -> Shift-IR -> load op -> Update-IR -> RTI, returning the captured bits
    task automatic load_ir(input logic [3:0] op, output logic [31:0] cap);
        int en;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(4, {28'h0, op}, cap, en);
        finish_dr();
    endtask

    task automatic test_reset();
        TRST = 1'b0;
        bus.TMS = 1'b1;
        bus.TDI = 1'b0;
        bus.BIST_STATUS = '0;
        #12;
        n_checks++; if (bus.TLR !== 1'b1) begin n_fail++; $display("FAIL reset_tlr_async: got %b want 1", bus.TLR); end
        n_checks++; if (bus.BSR !== 10'h000) begin n_fail++; $display("FAIL reset_bsr_async: got %h want 000", bus.BSR); end
        @(negedge TCK); #1;
        TRST = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        n_checks++; if (bus.TLR !== 1'b1) begin n_fail++; $display("FAIL reset_tlr: got %b want 1", bus.TLR); end
        n_checks++; if (bus.TDO_EN !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en: got %b want 0", bus.TDO_EN); end
        n_checks++; if (bus.UPDATEDR !== 1'b0 || bus.CAPTUREDR !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got upd=%b cap=%b want 0/0", bus.UPDATEDR, bus.CAPTUREDR); end
        n_checks++; if (bus.RUNBIST_SELECT !== 1'b0 || bus.GETTEST_SELECT !== 1'b0) begin n_fail++; $display("FAIL reset_selects: got rb=%b gt=%b want 0/0", bus.RUNBIST_SELECT, bus.GETTEST_SELECT); end
        step(1'b0, 1'b0);
        n_checks++; if (bus.TLR !== 1'b0) begin n_fail++; $display("FAIL rti_tlr: got %b want 0", bus.TLR); end
    endtask

    task automatic test_idcode();
        logic [31:0] d;
        int          en;
        step(1'b1, 1'b0);
        n_checks++; if (bus.CAPTUREDR !== 1'b0) begin n_fail++; $display("FAIL capdr_seldr: got %b want 0", bus.CAPTUREDR); end
        step(1'b0, 1'b0);
        n_checks++; if (bus.CAPTUREDR !== 1'b1) begin n_fail++; $display("FAIL capdr_pulse: got %b want 1", bus.CAPTUREDR); end
        step(1'b0, 1'b0);
        n_checks++; if (bus.CAPTUREDR !== 1'b0) begin n_fail++; $display("FAIL capdr_shdr: got %b want 0", bus.CAPTUREDR); end
        shift_bits(32, 32'h0, d, en);
        n_checks++; if (d !== 32'h1BEEF0A1) begin n_fail++; $display("FAIL idcode_tdo: got %h want 1beef0a1", d); end
        n_checks++; if (en != 32) begin n_fail++; $display("FAIL idcode_tdo_en_cycles: got %0d want 32", en); end
        n_checks++; if (bus.TDO_EN !== 1'b0) begin n_fail++; $display("FAIL idcode_tdo_en_exit: got %b want 0", bus.TDO_EN); end
        step(1'b1, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b1) begin n_fail++; $display("FAIL idcode_updatedr: got %b want 1", bus.UPDATEDR); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_pause();
        logic [31:0] d1, d2;
        int          e1, e2;
        goto_shdr();
        shift_bits(12, 32'h0, d1, e1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        n_checks++; if (bus.TDO_EN !== 1'b0) begin n_fail++; $display("FAIL pause_tdo_en: got %b want 0", bus.TDO_EN); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(20, 32'h0, d2, e2);
        n_checks++; if ({d2[19:0], d1[11:0]} !== 32'h1BEEF0A1) begin n_fail++; $display("FAIL pause_resume: got %h want 1beef0a1", {d2[19:0], d1[11:0]}); end
        finish_dr();
    endtask

    task automatic test_ir_scan();
        logic [31:0] cap;
        load_ir(4'h8, cap);
        n_checks++; if (cap[3:0] !== 4'b0001) begin n_fail++; $display("FAIL ir_capture: got %b want 0001", cap[3:0]); end
        n_checks++; if (bus.GETTEST_SELECT !== 1'b1 || bus.RUNBIST_SELECT !== 1'b0) begin n_fail++; $display("FAIL ir_gettest_sel: got gt=%b rb=%b want 1/0", bus.GETTEST_SELECT, bus.RUNBIST_SELECT); end
    endtask

    task automatic test_gettest();
        logic [31:0] d;
        int          en;
        goto_shdr();
        shift_bits(10, 32'h2A5, d, en);
        n_checks++; if (d[9:0] !== 10'h000) begin n_fail++; $display("FAIL gettest_cap0: got %h want 000", d[9:0]); end
        n_checks++; if (en != 10) begin n_fail++; $display("FAIL gettest_en_cycles: got %0d want 10", en); end
        n_checks++; if (bus.UPDATEDR !== 1'b0) begin n_fail++; $display("FAIL gettest_upd_ex1: got %b want 0", bus.UPDATEDR); end
        step(1'b1, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b1 || bus.BSR !== 10'h2A5) begin n_fail++; $display("FAIL gettest_load1: got upd=%b bsr=%h want 1/2a5", bus.UPDATEDR, bus.BSR); end
        step(1'b1, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b0) begin n_fail++; $display("FAIL gettest_pulse_width: got %b want 0", bus.UPDATEDR); end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        shift_bits(10, 32'h13C, d, en);
        n_checks++; if (d[9:0] !== 10'h2A5) begin n_fail++; $display("FAIL gettest_cap_bsr: got %h want 2a5", d[9:0]); end
        step(1'b1, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b1 || bus.BSR !== 10'h13C) begin n_fail++; $display("FAIL gettest_load2: got upd=%b bsr=%h want 1/13c", bus.UPDATEDR, bus.BSR); end
        step(1'b0, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b0 || bus.BSR !== 10'h13C) begin n_fail++; $display("FAIL gettest_rti: got upd=%b bsr=%h want 0/13c", bus.UPDATEDR, bus.BSR); end
    endtask

    task automatic test_status();
        logic [31:0] d, cap;
        int          en;
        bus.BIST_STATUS = 16'hC35F;
        load_ir(4'hA, cap);
        goto_shdr();
        shift_bits(16, 32'h0, d, en);
        n_checks++; if (d[15:0] !== 16'hC35F) begin n_fail++; $display("FAIL status_tdo: got %h want c35f", d[15:0]); end
        finish_dr();
    endtask

    task automatic test_runbist();
        logic [31:0] cap;
        load_ir(4'h9, cap);
        n_checks++; if (bus.RUNBIST_SELECT !== 1'b1 || bus.GETTEST_SELECT !== 1'b0) begin n_fail++; $display("FAIL runbist_sel: got rb=%b gt=%b want 1/0", bus.RUNBIST_SELECT, bus.GETTEST_SELECT); end
    endtask

    task automatic test_bypass();
        logic [31:0] d, cap;
        int          en;
        load_ir(4'h3, cap);
        n_checks++; if (bus.RUNBIST_SELECT !== 1'b0 || bus.GETTEST_SELECT !== 1'b0) begin n_fail++; $display("FAIL bypass_sel: got rb=%b gt=%b want 0/0", bus.RUNBIST_SELECT, bus.GETTEST_SELECT); end
        goto_shdr();
        shift_bits(8, 32'hB6, d, en);
        n_checks++; if (d[7:0] !== 8'h6C) begin n_fail++; $display("FAIL bypass_delay: got %h want 6c", d[7:0]); end
        finish_dr();
    endtask

    task automatic test_tlr_entry();
        logic [31:0] cap;
        load_ir(4'h8, cap);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        n_checks++; if (bus.TLR !== 1'b1) begin n_fail++; $display("FAIL tlr_entry: got %b want 1", bus.TLR); end
        n_checks++; if (bus.GETTEST_SELECT !== 1'b0) begin n_fail++; $display("FAIL tlr_ir_reset: got gt=%b want 0", bus.GETTEST_SELECT); end
        n_checks++; if (bus.BSR !== 10'h13C) begin n_fail++; $display("FAIL tlr_bsr_held: got %h want 13c", bus.BSR); end
        step(1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [31:0] cap;
        TRST = 1'b0;
        #2;
        TRST = 1'b1;
        @(negedge TCK); #1;
        step(1'b0, 1'b0);
        n_checks++; if (bus.BSR !== 10'h000) begin n_fail++; $display("FAIL abort_bsr_pre: got %h want 000", bus.BSR); end
        load_ir(4'h8, cap);
        goto_shdr();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        TRST = 1'b0;
        #1;
        n_checks++; if (bus.TLR !== 1'b1) begin n_fail++; $display("FAIL abort_tlr_async: got %b want 1", bus.TLR); end
        n_checks++; if (bus.TDO_EN !== 1'b0) begin n_fail++; $display("FAIL abort_tdo_en: got %b want 0", bus.TDO_EN); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_checks++; if (bus.UPDATEDR !== 1'b0 || bus.BSR !== 10'h000) begin n_fail++; $display("FAIL abort_no_update: got upd=%b bsr=%h want 0/000", bus.UPDATEDR, bus.BSR); end
        TRST = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        n_checks++; if (bus.BSR !== 10'h000 || bus.GETTEST_SELECT !== 1'b0) begin n_fail++; $display("FAIL abort_recover: got bsr=%h gt=%b want 000/0", bus.BSR, bus.GETTEST_SELECT); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_pause();
        test_ir_scan();
        test_gettest();
        test_status();
        test_runbist();
        test_bypass();
        test_tlr_entry();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
